// File: rtl/axi_stream_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
package axi_stream_arb_pkg;

   localparam int MAX_INPUTS = 16;
   localparam int IDX_W      = 4;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_PACKET = 1'b1
   } arb_state_e;

   // Converts a one-hot owner vector (zero-extended to MAX_INPUTS) to its index.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] onehot);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_INPUTS; i++) begin
         if (onehot[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake with data and end-of-packet.
interface axi_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_winner+1 with wrap.
module rr_arbiter #(
   parameter int NUM_INPUTS = 4,
   localparam int IDX_W     = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [IDX_W-1:0]      last_winner,
   output logic [NUM_INPUTS-1:0] winner,
   output logic                  valid
);

   int idx;

   // First requester found after the previous winner takes the grant.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         idx = int'(last_winner) + k;
         if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_stream_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS AXI-Stream inputs
// into one output through a single-entry output register.
module axi_stream_arbiter
   import axi_stream_arb_pkg::*;
#(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axi_stream_if.slave           s_axis [NUM_INPUTS],
   axi_stream_if.master          m_axis,
   output logic [NUM_INPUTS-1:0] grant,
   output logic                  busy
);

   localparam int LW_W = $clog2(NUM_INPUTS);

   arb_state_e              state_q, state_d;
   logic [NUM_INPUTS-1:0]   grant_q, grant_d;
   logic [LW_W-1:0]         last_winner_q, last_winner_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_last_q, out_last_d;

   logic [NUM_INPUTS-1:0]   req;
   logic [NUM_INPUTS-1:0]   in_last;
   logic [DATA_WIDTH-1:0]   in_data [NUM_INPUTS];
   logic [NUM_INPUTS-1:0]   rr_winner;
   logic                    rr_valid;
   logic                    owner_valid;
   logic                    owner_last;
   logic [DATA_WIDTH-1:0]   owner_data;
   logic [LW_W-1:0]         owner_idx;
   logic                    ready_in;
   logic                    accept;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
      assign req[i]            = s_axis[i].tvalid;
      assign in_last[i]        = s_axis[i].tlast;
      assign in_data[i]        = s_axis[i].tdata;
      assign s_axis[i].tready  = grant_q[i] & ready_in;
   end

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_rr (
      .req         (req),
      .last_winner (last_winner_q),
      .winner      (rr_winner),
      .valid       (rr_valid)
   );

   // Route the current owner's beat through a one-hot mux.
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant_q[i]) begin
            owner_valid = req[i];
            owner_last  = in_last[i];
            owner_data  = in_data[i];
         end
      end
   end

   assign owner_idx = LW_W'(onehot_to_idx(MAX_INPUTS'(grant_q)));
   assign ready_in  = (state_q == ARB_PACKET) & (~out_valid_q | m_axis.tready);
   assign accept    = ready_in & owner_valid;

   // Next-state: arbitration, packet lock/release and output register load/drain.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_winner_d = last_winner_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_last_d    = out_last_q;

      case (state_q)
         ARB_IDLE: begin
            if (rr_valid) begin
               grant_d = rr_winner;
               state_d = ARB_PACKET;
            end
         end
         ARB_PACKET: begin
            if (accept && owner_last) begin
               state_d       = ARB_IDLE;
               grant_d       = '0;
               last_winner_d = owner_idx;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = owner_data;
         out_last_d  = owner_last;
      end else if (m_axis.tready) begin
         out_valid_d = 1'b0;
      end
   end

   // All state registers; reset abandons any packet and buffered beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARB_IDLE;
         grant_q       <= '0;
         last_winner_q <= LW_W'(NUM_INPUTS - 1);
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_winner_q <= last_winner_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_last_q    <= out_last_d;
      end
   end

   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tdata  = out_data_q;
   assign m_axis.tlast  = out_last_q;
   assign grant         = grant_q;
   assign busy          = (state_q == ARB_PACKET) | out_valid_q;

endmodule

// File: tb/tb_axi_stream_arbiter.sv
// Directed bench for axi_stream_arbiter with an in-order beat scoreboard.
module tb_axi_stream_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  s_valid;
   logic [N-1:0]  s_last;
   logic [N-1:0]  s_ready;
   logic [W-1:0]  s_data [N];
   logic          m_ready;
   logic [N-1:0]  grant;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int gap_checks = 0;
   logic gap_active = 1'b0;
   logic [N-1:0] prev_grant = '0;

   beat_t        exp_q [$];
   logic [7:0]   out_dat [$];
   logic         out_lst [$];
   int           out_cyc [$];
   int           acc_cyc [$];
   logic [N-1:0] grant_log [$];
   logic [7:0]   exp_seq [$];
   logic [N-1:0] exp_grants [$];

   axi_stream_if #(.DATA_WIDTH(W)) s_if [N] ();
   axi_stream_if #(.DATA_WIDTH(W)) m_if ();

   for (genvar i = 0; i < N; i++) begin : g_conn
      assign s_if[i].tvalid = s_valid[i];
      assign s_if[i].tdata  = s_data[i];
      assign s_if[i].tlast  = s_last[i];
      assign s_ready[i]     = s_if[i].tready;
   end
   assign m_if.tready = m_ready;

   axi_stream_arbiter #(
      .NUM_INPUTS (N),
      .DATA_WIDTH (W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_axis (s_if),
      .m_axis (m_if),
      .grant  (grant),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: scoreboard pop, ready ownership rule, grant history, gap watch.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (m_if.tvalid && m_ready) begin
            if (exp_q.size() == 0) begin
               check_output("sb_extra_beat", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check_output("sb_data", m_if.tdata, e.data);
               check_output("sb_last", m_if.tlast, e.last);
            end
            out_dat.push_back(m_if.tdata);
            out_lst.push_back(m_if.tlast);
            out_cyc.push_back(cyc);
         end
         check_output("ready_not_owner", s_ready & ~grant, 0);
         check_output("ready_onehot", ($countones(s_ready) <= 1), 1);
         if (grant != prev_grant) begin
            if (grant != '0) grant_log.push_back(grant);
            prev_grant = grant;
         end
         if (gap_active) begin
            gap_checks++;
            check_output("gap_grant", grant, 4'b0001);
            check_output("gap_ready2", s_ready[2], 0);
         end
      end
   end

   task automatic apply_stimulus(input int src, input int n, input logic [7:0] first,
                                 input logic [7:0] step, input int gap_after, input int gap_len);
      for (int k = 0; k < n; k++) begin
         int waited;
         bit got;
         s_valid[src] = 1'b1;
         s_data[src]  = first + 8'(k) * step;
         s_last[src]  = (k == n - 1);
         waited = 0;
         got    = 1'b0;
         while (!got && waited < 200) begin
            @(negedge clk);
            if (s_ready[src]) got = 1'b1;
            else waited++;
         end
         if (!got) begin
            check_output("send_timeout", waited, 0);
            s_valid[src] = 1'b0;
            s_last[src]  = 1'b0;
            return;
         end
         exp_q.push_back('{data: s_data[src], last: s_last[src]});
         acc_cyc.push_back(cyc);
         @(posedge clk); #1;
         if (k == gap_after) begin
            s_valid[src] = 1'b0;
            gap_active   = 1'b1;
            repeat (gap_len) begin @(posedge clk); #1; end
            gap_active   = 1'b0;
         end
      end
      s_valid[src] = 1'b0;
      s_last[src]  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int w;
      bit done;
      w = 0;
      done = 1'b0;
      while (!done && w < 200) begin
         @(negedge clk);
         if (!busy && grant == '0) done = 1'b1;
         else w++;
      end
      check_output({tag, "_idle"}, done, 1);
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      out_dat.delete();
      out_lst.delete();
      out_cyc.delete();
      acc_cyc.delete();
      grant_log.delete();
   endtask

   task automatic check_seq(input string tag);
      check_output({tag, "_count"}, out_dat.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size(); i++) begin
         if (i < out_dat.size()) check_output($sformatf("%s_beat%0d", tag, i), out_dat[i], exp_seq[i]);
      end
   endtask

   task automatic check_grants(input string tag);
      check_output({tag, "_grant_count"}, grant_log.size(), exp_grants.size());
      for (int i = 0; i < exp_grants.size(); i++) begin
         if (i < grant_log.size()) check_output($sformatf("%s_grant%0d", tag, i), grant_log[i], exp_grants[i]);
      end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      s_valid = '1;
      s_last  = '0;
      for (int i = 0; i < N; i++) s_data[i] = '0;
      m_ready = 1'b1;

      // Reset state, with requests present to show they are ignored.
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_output("rst_grant", grant, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_tvalid", m_if.tvalid, 0);
      check_output("rst_tdata", m_if.tdata, 0);
      check_output("rst_tlast", m_if.tlast, 0);
      check_output("rst_tready", s_ready, 0);
      s_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Three-beat packet from input 2.
      clear_logs();
      fork
         apply_stimulus(2, 3, 8'h11, 8'h11, -1, 0);
         begin
            @(negedge clk);
            check_output("t1_grant_before", grant, 0);
            @(negedge clk);
            check_output("t1_grant", grant, 4'b0100);
            check_output("t1_busy", busy, 1);
         end
      join
      wait_idle("t1");
      exp_seq = '{8'h11, 8'h22, 8'h33};
      check_seq("t1");
      if (out_dat.size() == 3 && acc_cyc.size() == 3) begin
         check_output("t1_consecutive", out_cyc[2] - out_cyc[0], 2);
         check_output("t1_tlast", {out_lst[0], out_lst[1], out_lst[2]}, 3'b001);
         check_output("t1_latency", out_cyc[0] - acc_cyc[0], 1);
      end

      // Inputs 0 and 1 stream two-beat packets back to back.
      clear_logs();
      fork
         begin
            apply_stimulus(0, 2, 8'h01, 8'h01, -1, 0);
            apply_stimulus(0, 2, 8'h03, 8'h01, -1, 0);
         end
         begin
            apply_stimulus(1, 2, 8'h81, 8'h01, -1, 0);
            apply_stimulus(1, 2, 8'h83, 8'h01, -1, 0);
         end
      join
      wait_idle("t2");
      exp_seq = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84};
      check_seq("t2");
      exp_grants = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
      check_grants("t2");
      if (out_cyc.size() == 8) begin
         check_output("t2_bubble1", out_cyc[2] - out_cyc[1], 2);
         check_output("t2_bubble2", out_cyc[4] - out_cyc[3], 2);
         check_output("t2_inpkt", out_cyc[1] - out_cyc[0], 1);
      end

      // Downstream stall of 4 cycles in the middle of an input 3 packet.
      clear_logs();
      fork
         apply_stimulus(3, 6, 8'h30, 8'h01, -1, 0);
         begin
            int w;
            bit seen;
            w = 0;
            seen = 1'b0;
            while (!seen && w < 100) begin
               @(negedge clk);
               if (m_if.tvalid && m_if.tdata == 8'h32) seen = 1'b1;
               else w++;
            end
            check_output("t3_seen", seen, 1);
            @(posedge clk); #1;
            m_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check_output("t3_hold_valid", m_if.tvalid, 1);
               check_output("t3_hold_data", m_if.tdata, 8'h33);
               check_output("t3_ready3", s_ready[3], 0);
               check_output("t3_busy", busy, 1);
               @(posedge clk); #1;
            end
            m_ready = 1'b1;
         end
      join
      wait_idle("t3");
      exp_seq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      check_seq("t3");

      // Single-beat packets from inputs 1 and 2 competing.
      clear_logs();
      fork
         repeat (3) apply_stimulus(1, 1, 8'hA5, 8'h00, -1, 0);
         repeat (3) apply_stimulus(2, 1, 8'hB2, 8'h00, -1, 0);
      join
      wait_idle("t4");
      exp_seq = '{8'hA5, 8'hB2, 8'hA5, 8'hB2, 8'hA5, 8'hB2};
      check_seq("t4");
      exp_grants = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0100};
      check_grants("t4");
      if (out_lst.size() == 6) begin
         check_output("t4_all_tlast", {out_lst[0], out_lst[1], out_lst[2], out_lst[3], out_lst[4], out_lst[5]}, 6'b111111);
      end

      // Reset in the middle of a four-beat packet from input 0.
      clear_logs();
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h41;
      s_last[0]  = 1'b0;
      exp_q.push_back('{data: 8'h41, last: 1'b0});
      @(posedge clk); #1;
      @(negedge clk);
      check_output("t5_grant", grant, 4'b0001);
      check_output("t5_ready0", s_ready[0], 1);
      @(posedge clk); #1;
      s_data[0] = 8'h42;
      @(negedge clk);
      check_output("t5_ready0_b2", s_ready[0], 1);
      @(posedge clk); #1;
      s_data[0] = 8'h43;
      s_valid[1] = 1'b1; s_data[1] = 8'h51; s_last[1] = 1'b1;
      s_valid[3] = 1'b1; s_data[3] = 8'h3F; s_last[3] = 1'b1;
      check_output("t5_pre_rst_tvalid", m_if.tvalid, 1);
      check_output("t5_pre_rst_tdata", m_if.tdata, 8'h42);
      rst_n = 1'b0;
      #1;
      check_output("t5_rst_tvalid", m_if.tvalid, 0);
      check_output("t5_rst_grant", grant, 0);
      check_output("t5_rst_busy", busy, 0);
      check_output("t5_rst_tdata", m_if.tdata, 0);
      check_output("t5_rst_tready", s_ready, 0);
      s_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      fork
         apply_stimulus(1, 1, 8'h51, 8'h00, -1, 0);
         apply_stimulus(3, 1, 8'h3F, 8'h00, -1, 0);
         begin
            @(negedge clk);
            check_output("t5_no_early_arb", grant, 0);
            @(negedge clk);
            check_output("t5_grant_after_rst", grant, 4'b0010);
         end
      join
      wait_idle("t5");
      exp_seq = '{8'h41, 8'h51, 8'h3F};
      check_seq("t5");

      // Owner pauses for 3 cycles mid-packet while input 2 waits.
      clear_logs();
      gap_checks = 0;
      fork
         apply_stimulus(0, 4, 8'h61, 8'h01, 1, 3);
         apply_stimulus(2, 2, 8'h71, 8'h01, -1, 0);
      join
      wait_idle("t6");
      check_output("t6_gap_cycles", gap_checks, 3);
      exp_seq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h72};
      check_seq("t6");
      exp_grants = '{4'b0001, 4'b0100};
      check_grants("t6");

      check_output("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_stream_arbiter.md
AXI_STREAM_ARBITER -- requirements
Module: axi_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of upstream streams (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, tdata width of all streams.
REQ-003 SHALL have port clk, input, 1, single clock; all logic SHALL be rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_axis, axi_stream_if.slave array [NUM_INPUTS], DATA_WIDTH, upstream requesters.
REQ-006 SHALL have port m_axis, axi_stream_if.master, DATA_WIDTH, shared downstream stream.
REQ-007 SHALL have port grant, output, NUM_INPUTS, one-hot current owner, all zero when idle.
REQ-008 SHALL have port busy, output, 1, high while a packet is in progress.

Function
REQ-009 SHALL arbitrate per packet: once granted, an input owns m_axis until its tlast beat is accepted.
REQ-010 SHALL use a two-state FSM: IDLE (no owner), PACKET (owner locked).
REQ-011 IDLE: if any s_axis[i].tvalid is high, SHALL register grant to the round-robin winner and go to PACKET next cycle; otherwise stay in IDLE.
REQ-012 Round-robin search SHALL start at index (last_winner+1) mod NUM_INPUTS and wrap; after reset last_winner = NUM_INPUTS-1, so index 0 has first priority.
REQ-013 PACKET: s_axis[g].tready = ~out_valid | m_axis.tready for owner g; every other s_axis tready SHALL be 0.
REQ-014 In IDLE, all s_axis tready SHALL be 0.
REQ-015 An upstream beat SHALL be accepted when owner tvalid & tready; the beat (tdata, tlast) SHALL be loaded into a one-entry output register.
REQ-016 m_axis.tvalid/tdata/tlast SHALL come directly from the output register; out_valid SHALL clear on m_axis.tready when no new beat is loaded the same cycle.
REQ-017 Simultaneous load and drain SHALL keep out_valid = 1 with the new beat (full throughput, 1 beat/cycle within a packet).
REQ-018 Latency: beat accepted in cycle N SHALL appear on m_axis in cycle N+1.
REQ-019 Acceptance of a tlast beat SHALL move FSM to IDLE next cycle, set last_winner = g, clear grant; the output register continues draining independently.
REQ-020 Between packets there SHALL be exactly one IDLE arbitration cycle (one-cycle bubble on the input side).
REQ-021 Single-beat packets (tlast on first beat) SHALL be handled per REQ-019.
REQ-022 Owner deasserting tvalid mid-packet SHALL NOT release the grant; the arbiter waits.
REQ-023 m_axis.tvalid, once high, SHALL hold with stable tdata/tlast until m_axis.tready.
REQ-024 busy SHALL equal (state == PACKET) | out_valid.
REQ-025 Non-owner tvalid changes SHALL have no effect on m_axis or grant during PACKET.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, grant 0, busy 0, out_valid 0 (m_axis.tvalid 0), tdata 0, tlast 0, last_winner NUM_INPUTS-1, all s_axis tready 0.
REQ-027 Reset mid-packet SHALL abandon the packet and any buffered beat; no resumption.
REQ-028 Reset deassertion SHALL be used synchronously to clk; first arbitration no earlier than the first clk edge after release.

Structure
REQ-029 Package axi_stream_arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_PACKET) and the NUM_INPUTS max constant (16).
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last_winner in; one-hot winner, valid out; purely combinational).
REQ-031 Output register and FSM SHALL live in axi_stream_arbiter.

Verification
REQ-032 Reset then s_axis[2] sends 3 beats 0x11,0x22,0x33(tlast), m_axis.tready=1 -> grant=4'b0100 one cycle after tvalid; m_axis shows 0x11,0x22,0x33 on consecutive cycles, tlast on 0x33.
REQ-033 Inputs 0 and 1 both send a 2-beat packet continuously -> packets alternate 0,1,0,1; one bubble cycle between packets; no interleaving of beats.
REQ-034 Input 3 mid-packet, m_axis.tready low 4 cycles -> m_axis.tvalid held with stable tdata, s_axis[3].tready=0 while register full, no beat lost or duplicated.
REQ-035 Input 1 sends single-beat packets (0xA5, tlast) back-to-back while input 2 also requests -> grants alternate 1,2; each beat appears with tlast=1.
REQ-036 rst_n pulled low after 2nd of 4 beats from input 0 -> m_axis.tvalid, grant, busy all 0 immediately; after release, input 1 request wins with grant=4'b0010 on next arbitration (pointer reset, index 0 not requesting).
REQ-037 Owner drops tvalid 3 cycles mid-packet while input 2 requests -> grant stays on owner; input 2 served only after owner's tlast.
